iss_mc_core: RTL and testbench
==============================

Name: iss_mc_core

Overview:
- Parametrised multi-cycle RV32I/RV32E instruction-set simulator control unit.
- Sits between the memory model and the register file.
- Fetches, decodes and executes one instruction at a time over sync/notify handshakes.
- Adds what the previous ISS lacked: a configurable register count, reset and trap vectors, precise traps for illegal/system instructions, x0 write suppression, correct store data (rs2) and a retired-instruction counter.

Parameters:
- XLEN, 32: data/address width; only 32 is legal.
- NUM_REGS, 32: architectural registers; 32 (RV32I) or 16 (RV32E).
- RESET_PC, 32'h0000_0000: first fetch address.
- TRAP_VEC, 32'h0000_0100: PC loaded on any trap.
- CNT_W, 32: retired-counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fromRegsPort  in  NUM_REGS*XLEN  register file snapshot; reg i at [i*XLEN +: XLEN]
- fromMemoryPort_loadeddata  in  XLEN  fetched instruction or load data (already extended per mask)
- fromMemoryPort_sync  in  1  memory response valid
- fromMemoryPort_notify  out  1  core ready for response
- toMemoryPort_addrin  out  XLEN  request address
- toMemoryPort_datain  out  XLEN  store data
- toMemoryPort_mask  out  3  0=b, 1=h, 2=w, 3=bu, 4=hu
- toMemoryPort_req  out  1  0=read, 1=write
- toMemoryPort_sync  in  1  memory accepted request
- toMemoryPort_notify  out  1  request valid
- toRegsPort_dst  out  5  destination register
- toRegsPort_dstdata  out  XLEN  write data
- toRegsPort_notify  out  1  one-cycle write strobe
- trap_valid  out  1  one-cycle trap pulse
- trap_cause  out  4  0=instr misaligned, 2=illegal, 3=ebreak, 4=load misaligned, 6=store misaligned, 11=ecall
- retired_count  out  CNT_W  instructions retired

Behaviour:
- Reset (rst=0, async) values:
  - phase=FETCH, pc=RESET_PC.
  - toMemoryPort_notify=1, addrin=RESET_PC, datain=0, mask=w, req=read.
  - fromMemoryPort_notify=0, toRegsPort_notify=0, dst=0, dstdata=0.
  - trap_valid=0, trap_cause=0, retired_count=0.
  - Reset mid-transaction abandons the transaction; no partial register write or count.
- Handshake rules:
  - A notify stays high until its sync is sampled high at a rising edge; notify deasserts at that edge.
  - Address, data, mask and req are stable while toMemoryPort_notify=1.
  - A sync seen while the matching notify is low is ignored.
- FETCH: on toMemoryPort_sync: toMemoryPort_notify<=0, fromMemoryPort_notify<=1, go to EXEC.
- EXEC: on fromMemoryPort_sync: latch instr, fromMemoryPort_notify<=0; rs1/rs2 read from fromRegsPort.
  - R/I-ALU: dstdata=ALU result; pc+=4.
  - LUI: dstdata=imm_u. AUIPC: dstdata=pc+imm_u; pc+=4.
  - JAL: dstdata=pc+4; pc+=imm_j.
  - JALR: dstdata=pc+4; pc=(rs1+imm_i)&~1.
  - Branch: pc = taken ? pc+imm_b : pc+4.
  - FENCE: no-op; pc+=4.
  - Load/store:
    - addrin=rs1+imm; mask from funct3.
    - Store: req=write, datain=rs2 value.
    - Load: req=read, datain=0.
    - toMemoryPort_notify<=1, go to MEMREQ.
  - All non-memory instructions: addrin<=new pc, toMemoryPort_notify<=1, go to FETCH, retired_count+=1.
  - Register write: toRegsPort_notify pulses high for exactly one cycle, only when the opcode writes rd and rd!=0. dst=instr[11:7].
- MEMREQ: on toMemoryPort_sync: fromMemoryPort_notify<=1, go to MEMDONE.
- MEMDONE: on fromMemoryPort_sync:
  - Load with rd!=0: dstdata=loadeddata, toRegsPort_notify pulse.
  - pc+=4; fetch request issued (addrin=pc, mask=w, req=read, datain=0, notify=1).
  - retired_count+=1; go to FETCH.
- Traps, taken in EXEC with no side effects (no regs write, no memory request, no count):
  - Illegal: unknown opcode, or rs1/rs2/rd >= NUM_REGS.
  - ECALL and EBREAK.
  - Response: trap_valid pulses one cycle with trap_cause; pc=TRAP_VEC; fetch issued from TRAP_VEC.
- Arithmetic: all modulo 2^XLEN. retired_count wraps from all-ones to 0.

Optional Feature:
- Macro: ISS_MISALIGN_TRAP_EN.
- Defined:
  - New pc with pc[1:0]!=0 after a jump or taken branch raises cause 0.
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, raises cause 4 (load) or 6 (store); no memory request is issued.
- Undefined: no alignment checks; addresses are passed to memory unchanged.

Test Plan:
- Reset release with RESET_PC=0x40 → addrin=0x40, toMemoryPort_notify=1; other notifies, trap_valid and retired_count=0.
- ADDI x5,x0,7 fetched → one-cycle toRegsPort_notify, dst=5, dstdata=7; next fetch at pc+4; retired_count=1.
- SW x6,8(x2) with x2=0x100, x6=0xDEADBEEF → req=write, addrin=0x108, datain=0xDEADBEEF, mask=w; no regs write.
- LW x0 followed by ADDI x0,x0,1 → both retire and retired_count+=2; toRegsPort_notify stays 0.
- Opcode 0x7F, and NUM_REGS=16 with ADD x17 → trap_valid pulse, cause=2; next fetch at 0x100; count unchanged.
- ISS_MISALIGN_TRAP_EN with LW from 0x102 → cause=4, no MEMREQ; without the macro → memory request at 0x102.

Source files
------------

// File: rtl/iss_mc_core.sv
// iss_mc_core: multi-cycle RV32I/RV32E instruction-set simulator control unit.
// One instruction at a time: FETCH -> EXEC [-> MEMREQ -> MEMDONE] -> FETCH.
// Every request/response uses a notify/sync pair. A notify stays high until its
// sync is sampled high on a rising edge.
//
// Optional build macro ISS_MISALIGN_TRAP_EN: when defined, misaligned jump
// targets and misaligned load/store addresses trap. When undefined, there are
// no alignment checks.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-low reset
//   fromRegsPort               register file snapshot, reg i at [i*XLEN +: XLEN]
//   fromMemoryPort_*           memory response: loadeddata/sync in, notify out
//   toMemoryPort_*             memory request: addrin/datain/mask/req/notify out, sync in
//   toRegsPort_*               register write: dst/dstdata, one-cycle notify strobe
//   trap_valid, trap_cause     one-cycle trap pulse and its cause
//   retired_count              retired-instruction counter
module iss_mc_core #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       NUM_REGS = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VEC = 32'h0000_0100,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REGS*XLEN-1:0] fromRegsPort,
  input  logic [XLEN-1:0]          fromMemoryPort_loadeddata,
  input  logic                     fromMemoryPort_sync,
  output logic                     fromMemoryPort_notify,
  output logic [XLEN-1:0]          toMemoryPort_addrin,
  output logic [XLEN-1:0]          toMemoryPort_datain,
  output logic [2:0]               toMemoryPort_mask,
  output logic                     toMemoryPort_req,
  input  logic                     toMemoryPort_sync,
  output logic                     toMemoryPort_notify,
  output logic [4:0]               toRegsPort_dst,
  output logic [XLEN-1:0]          toRegsPort_dstdata,
  output logic                     toRegsPort_notify,
  output logic                     trap_valid,
  output logic [3:0]               trap_cause,
  output logic [CNT_W-1:0]         retired_count
);
  localparam int unsigned RIDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] PH_FETCH = 2'd0, PH_EXEC = 2'd1, PH_MEMREQ = 2'd2, PH_MEMDONE = 2'd3;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67,
                         OPC_BR = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_OPIMM = 7'h13,
                         OPC_OP = 7'h33, OPC_FENCE = 7'h0F, OPC_SYS = 7'h73;

  localparam logic [2:0] MASK_B = 3'd0, MASK_H = 3'd1, MASK_W = 3'd2, MASK_BU = 3'd3, MASK_HU = 3'd4;

  localparam logic [3:0] CAUSE_IMIS = 4'd0, CAUSE_ILL = 4'd2, CAUSE_BRK = 4'd3,
                         CAUSE_LMIS = 4'd4, CAUSE_SMIS = 4'd6, CAUSE_ECALL = 4'd11;

  logic [1:0]      phase_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      mem_rd_q;
  logic            mem_load_q;

  // Decode fields straight off the response bus; they are only consumed on the
  // EXEC handshake edge.
  logic [XLEN-1:0] ins;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins    = fromMemoryPort_loadeddata;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign imm_i  = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s  = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  logic [XLEN-1:0] rf [NUM_REGS];
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] = fromRegsPort[i*XLEN +: XLEN];
  end

  logic rs1_ok, rs2_ok, rd_ok;
  assign rs1_ok = {1'b0, rs1} < 6'(NUM_REGS);
  assign rs2_ok = {1'b0, rs2} < 6'(NUM_REGS);
  assign rd_ok  = {1'b0, rd}  < 6'(NUM_REGS);

  logic [XLEN-1:0] a, rs2_val, b, alu;
  assign a       = (rs1_ok && rs1 != 5'd0) ? rf[rs1[RIDX_W-1:0]] : '0;
  assign rs2_val = (rs2_ok && rs2 != 5'd0) ? rf[rs2[RIDX_W-1:0]] : '0;
  assign b       = (opcode == OPC_OP) ? rs2_val : imm_i;

  always_comb begin
    alu = '0;
    case (f3)
      3'd0: alu = (opcode == OPC_OP && ins[30]) ? a - b : a + b;
      3'd1: alu = a << b[4:0];
      3'd2: alu[0] = $signed(a) < $signed(b);
      3'd3: alu[0] = a < b;
      3'd4: alu = a ^ b;
      3'd5: alu = ins[30] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: alu = a | b;
      3'd7: alu = a & b;
    endcase
  end

  logic            use_rd, use_rs1, use_rs2, redirect, taken, ex_mem, ex_we, ex_trap, illegal;
  logic [XLEN-1:0] ex_data, ex_pc, ex_addr, jalr_t;
  logic [2:0]      ex_mask;
  logic [3:0]      ex_cause;

  assign jalr_t = a + imm_i;

  always_comb begin
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; redirect = 1'b0; taken = 1'b0;
    ex_mem = 1'b0; ex_we = 1'b0; ex_trap = 1'b0; illegal = 1'b0;
    ex_data = '0; ex_pc = pc_q + 4; ex_addr = a + imm_i; ex_mask = MASK_W; ex_cause = CAUSE_ILL;
    case (opcode)
      OPC_LUI:   begin use_rd = 1'b1; ex_data = imm_u; end
      OPC_AUIPC: begin use_rd = 1'b1; ex_data = pc_q + imm_u; end
      OPC_JAL:   begin use_rd = 1'b1; ex_data = pc_q + 4; ex_pc = pc_q + imm_j; redirect = 1'b1; end
      OPC_JALR:  begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_data = pc_q + 4;
        ex_pc = {jalr_t[XLEN-1:1], 1'b0}; redirect = 1'b1;
      end
      OPC_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0: taken = a == rs2_val;
          3'd1: taken = a != rs2_val;
          3'd4: taken = $signed(a) <  $signed(rs2_val);
          3'd5: taken = $signed(a) >= $signed(rs2_val);
          3'd6: taken = a <  rs2_val;
          3'd7: taken = a >= rs2_val;
          default: illegal = 1'b1;
        endcase
        if (taken) begin ex_pc = pc_q + imm_b; redirect = 1'b1; end
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; ex_mem = 1'b1;
        case (f3)
          3'd0: ex_mask = MASK_B;
          3'd1: ex_mask = MASK_H;
          3'd2: ex_mask = MASK_W;
          3'd4: ex_mask = MASK_BU;
          3'd5: ex_mask = MASK_HU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ex_mem = 1'b1; ex_we = 1'b1; ex_addr = a + imm_s;
        case (f3)
          3'd0: ex_mask = MASK_B;
          3'd1: ex_mask = MASK_H;
          3'd2: ex_mask = MASK_W;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin use_rd = 1'b1; use_rs1 = 1'b1; ex_data = alu; end
      OPC_OP:    begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; ex_data = alu; end
      OPC_FENCE: ;
      OPC_SYS: begin
        ex_trap = 1'b1;
        if (ins[31:7] == 25'd0)                ex_cause = CAUSE_ECALL;
        else if (ins[31:7] == {12'd1, 13'd0})  ex_cause = CAUSE_BRK;
        else                                   ex_cause = CAUSE_ILL;
      end
      default: illegal = 1'b1;
    endcase
    if ((use_rd && !rd_ok) || (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok)) illegal = 1'b1;
    if (illegal) begin ex_trap = 1'b1; ex_cause = CAUSE_ILL; end
`ifdef ISS_MISALIGN_TRAP_EN
    if (!ex_trap) begin
      if (redirect && ex_pc[1:0] != 2'b00) begin
        ex_trap = 1'b1; ex_cause = CAUSE_IMIS;
      end else if (ex_mem && (((ex_mask == MASK_H || ex_mask == MASK_HU) && ex_addr[0]) ||
                              (ex_mask == MASK_W && ex_addr[1:0] != 2'b00))) begin
        ex_trap = 1'b1; ex_cause = ex_we ? CAUSE_SMIS : CAUSE_LMIS;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_FETCH; pc_q <= RESET_PC; mem_rd_q <= '0; mem_load_q <= 1'b0;
      toMemoryPort_notify <= 1'b1; toMemoryPort_addrin <= RESET_PC; toMemoryPort_datain <= '0;
      toMemoryPort_mask <= MASK_W; toMemoryPort_req <= 1'b0; fromMemoryPort_notify <= 1'b0;
      toRegsPort_notify <= 1'b0; toRegsPort_dst <= '0; toRegsPort_dstdata <= '0;
      trap_valid <= 1'b0; trap_cause <= '0; retired_count <= '0;
    end else begin
      toRegsPort_notify <= 1'b0;
      trap_valid        <= 1'b0;
      case (phase_q)
        PH_FETCH, PH_MEMREQ: if (toMemoryPort_notify && toMemoryPort_sync) begin
          toMemoryPort_notify   <= 1'b0;
          fromMemoryPort_notify <= 1'b1;
          phase_q <= (phase_q == PH_FETCH) ? PH_EXEC : PH_MEMDONE;
        end
        PH_EXEC: if (fromMemoryPort_notify && fromMemoryPort_sync) begin
          fromMemoryPort_notify <= 1'b0;
          toMemoryPort_notify   <= 1'b1;
          if (ex_trap) begin
            trap_valid <= 1'b1; trap_cause <= ex_cause; pc_q <= TRAP_VEC;
            toMemoryPort_addrin <= TRAP_VEC; toMemoryPort_mask <= MASK_W;
            toMemoryPort_req <= 1'b0; toMemoryPort_datain <= '0;
            phase_q <= PH_FETCH;
          end else if (ex_mem) begin
            // pc stays on the load/store; MEMDONE advances it after retirement.
            mem_rd_q <= rd; mem_load_q <= !ex_we;
            toMemoryPort_addrin <= ex_addr; toMemoryPort_mask <= ex_mask;
            toMemoryPort_req <= ex_we; toMemoryPort_datain <= ex_we ? rs2_val : '0;
            phase_q <= PH_MEMREQ;
          end else begin
            if (use_rd && rd != 5'd0) begin
              toRegsPort_notify <= 1'b1; toRegsPort_dst <= rd; toRegsPort_dstdata <= ex_data;
            end
            pc_q <= ex_pc; toMemoryPort_addrin <= ex_pc; toMemoryPort_mask <= MASK_W;
            toMemoryPort_req <= 1'b0; toMemoryPort_datain <= '0;
            retired_count <= retired_count + CNT_W'(1);
            phase_q <= PH_FETCH;
          end
        end
        PH_MEMDONE: if (fromMemoryPort_notify && fromMemoryPort_sync) begin
          fromMemoryPort_notify <= 1'b0;
          if (mem_load_q && mem_rd_q != 5'd0) begin
            toRegsPort_notify <= 1'b1; toRegsPort_dst <= mem_rd_q;
            toRegsPort_dstdata <= fromMemoryPort_loadeddata;
          end
          pc_q <= pc_q + 4; toMemoryPort_addrin <= pc_q + 4; toMemoryPort_mask <= MASK_W;
          toMemoryPort_req <= 1'b0; toMemoryPort_datain <= '0; toMemoryPort_notify <= 1'b1;
          retired_count <= retired_count + CNT_W'(1);
          phase_q <= PH_FETCH;
        end
        default: phase_q <= PH_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_iss_mc_core.sv
module tb_iss_mc_core;
  localparam int unsigned NR = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*32-1:0]  regs_flat;
  logic [31:0]       rf [NR];
  logic [31:0]       ld_data;
  logic              ld_sync, fm_notify;
  logic [31:0]       addrin, datain;
  logic [2:0]        mask;
  logic              req, tm_sync, tm_notify;
  logic [4:0]        dst;
  logic [31:0]       dstdata;
  logic              rg_notify, trap_valid;
  logic [3:0]        trap_cause;
  logic [31:0]       retired;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) regs_flat[i*32 +: 32] = rf[i];
  end

  iss_mc_core #(
    .XLEN(32), .NUM_REGS(NR), .RESET_PC(32'h0000_0040), .TRAP_VEC(32'h0000_0100), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .fromRegsPort(regs_flat),
    .fromMemoryPort_loadeddata(ld_data), .fromMemoryPort_sync(ld_sync),
    .fromMemoryPort_notify(fm_notify),
    .toMemoryPort_addrin(addrin), .toMemoryPort_datain(datain), .toMemoryPort_mask(mask),
    .toMemoryPort_req(req), .toMemoryPort_sync(tm_sync), .toMemoryPort_notify(tm_notify),
    .toRegsPort_dst(dst), .toRegsPort_dstdata(dstdata), .toRegsPort_notify(rg_notify),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .retired_count(retired)
  );

  // Accept the pending request, then answer it with 'data'.
  task automatic handshake(input logic [31:0] data);
    int n;
    n = 0;
    while (!tm_notify && n < 50) begin @(negedge clk); n++; end
    total++; if (tm_notify !== 1'b1) begin bad++; $display("FAIL req_timeout got=%b want=1", tm_notify); end
    tm_sync = 1'b1; @(negedge clk); tm_sync = 1'b0;
    n = 0;
    while (!fm_notify && n < 50) begin @(negedge clk); n++; end
    total++; if (fm_notify !== 1'b1) begin bad++; $display("FAIL rsp_timeout got=%b want=1", fm_notify); end
    ld_data = data; ld_sync = 1'b1; @(negedge clk); ld_sync = 1'b0; ld_data = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0; tm_sync = 1'b0; ld_sync = 1'b0; ld_data = '0;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    total++; if (addrin !== 32'h40) begin bad++; $display("FAIL rst_addr got=%h want=00000040", addrin); end
    total++; if (tm_notify !== 1'b1) begin bad++; $display("FAIL rst_tm_notify got=%b want=1", tm_notify); end
    total++; if ({fm_notify, rg_notify, trap_valid} !== 3'b000) begin bad++; $display("FAIL rst_notifies got=%b want=000", {fm_notify, rg_notify, trap_valid}); end
    total++; if ({mask, req, datain} !== {3'd2, 1'b0, 32'h0}) begin bad++; $display("FAIL rst_req got=%h/%b/%h want=2/0/0", mask, req, datain); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", retired); end
    @(negedge clk);
  endtask

  task automatic test_addi;
    handshake(32'h0070_0293);                     // addi x5,x0,7 @0x40
    total++; if ({rg_notify, dst, dstdata} !== {1'b1, 5'd5, 32'd7}) begin bad++; $display("FAIL addi_wr got=%b/%0d/%h want=1/5/7", rg_notify, dst, dstdata); end
    total++; if ({tm_notify, addrin} !== {1'b1, 32'h44}) begin bad++; $display("FAIL addi_next got=%b/%h want=1/44", tm_notify, addrin); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL addi_count got=%0d want=1", retired); end
    @(negedge clk);
    total++; if (rg_notify !== 1'b0) begin bad++; $display("FAIL addi_pulse got=%b want=0", rg_notify); end
  endtask

  task automatic test_store;
    rf[2] = 32'h100; rf[6] = 32'hDEAD_BEEF;
    handshake(32'h0061_2423);                     // sw x6,8(x2) @0x44
    total++; if ({req, mask, addrin, datain} !== {1'b1, 3'd2, 32'h108, 32'hDEAD_BEEF}) begin bad++; $display("FAIL sw_req got=%b/%0d/%h/%h want=1/2/108/deadbeef", req, mask, addrin, datain); end
    total++; if ({tm_notify, rg_notify, retired} !== {2'b10, 32'd1}) begin bad++; $display("FAIL sw_exec got=%b/%b/%0d want=1/0/1", tm_notify, rg_notify, retired); end
    handshake(32'h0);
    total++; if ({rg_notify, retired} !== {1'b0, 32'd2}) begin bad++; $display("FAIL sw_done got=%b/%0d want=0/2", rg_notify, retired); end
    total++; if ({addrin, req, datain} !== {32'h48, 1'b0, 32'h0}) begin bad++; $display("FAIL sw_fetch got=%h/%b/%h want=48/0/0", addrin, req, datain); end
  endtask

  task automatic test_x0_writes;
    handshake(32'h0001_2003);                     // lw x0,0(x2) @0x48
    total++; if ({addrin, req, mask} !== {32'h100, 1'b0, 3'd2}) begin bad++; $display("FAIL lwx0_req got=%h/%b/%0d want=100/0/2", addrin, req, mask); end
    handshake(32'hCAFE_F00D);
    total++; if ({rg_notify, retired, addrin} !== {1'b0, 32'd3, 32'h4C}) begin bad++; $display("FAIL lwx0_done got=%b/%0d/%h want=0/3/4c", rg_notify, retired, addrin); end
    handshake(32'h0010_0013);                     // addi x0,x0,1 @0x4C
    total++; if ({rg_notify, retired, addrin} !== {1'b0, 32'd4, 32'h50}) begin bad++; $display("FAIL addix0 got=%b/%0d/%h want=0/4/50", rg_notify, retired, addrin); end
  endtask

  task automatic test_load;
    handshake(32'h0041_2383);                     // lw x7,4(x2) @0x50
    total++; if (addrin !== 32'h104) begin bad++; $display("FAIL lw_addr got=%h want=104", addrin); end
    handshake(32'h1234_5678);
    total++; if ({rg_notify, dst, dstdata} !== {1'b1, 5'd7, 32'h1234_5678}) begin bad++; $display("FAIL lw_wr got=%b/%0d/%h want=1/7/12345678", rg_notify, dst, dstdata); end
    total++; if ({retired, addrin} !== {32'd5, 32'h54}) begin bad++; $display("FAIL lw_next got=%0d/%h want=5/54", retired, addrin); end
  endtask

  task automatic test_flow;
    handshake(32'h0100_00EF);                     // jal x1,+16 @0x54
    total++; if ({dst, dstdata, addrin} !== {5'd1, 32'h58, 32'h64}) begin bad++; $display("FAIL jal got=%0d/%h/%h want=1/58/64", dst, dstdata, addrin); end
    handshake(32'h0000_0463);                     // beq x0,x0,+8 @0x64
    total++; if ({rg_notify, addrin} !== {1'b0, 32'h6C}) begin bad++; $display("FAIL beq got=%b/%h want=0/6c", rg_notify, addrin); end
    handshake(32'h0000_1463);                     // bne x0,x0,+8 @0x6C
    total++; if ({addrin, retired} !== {32'h70, 32'd8}) begin bad++; $display("FAIL bne got=%h/%0d want=70/8", addrin, retired); end
    handshake(32'h4023_01B3);                     // sub x3,x6,x2 @0x70
    total++; if ({dst, dstdata, addrin} !== {5'd3, 32'hDEAD_BDEF, 32'h74}) begin bad++; $display("FAIL sub got=%0d/%h/%h want=3/deadbdef/74", dst, dstdata, addrin); end
  endtask

  task automatic test_trap;
    handshake(32'h0000_007F);                     // unknown opcode @0x74
    total++; if ({trap_valid, trap_cause} !== {1'b1, 4'd2}) begin bad++; $display("FAIL ill_trap got=%b/%0d want=1/2", trap_valid, trap_cause); end
    total++; if ({addrin, retired, rg_notify} !== {32'h100, 32'd9, 1'b0}) begin bad++; $display("FAIL ill_state got=%h/%0d/%b want=100/9/0", addrin, retired, rg_notify); end
    @(negedge clk);
    total++; if (trap_valid !== 1'b0) begin bad++; $display("FAIL trap_pulse got=%b want=0", trap_valid); end
    handshake(32'h0020_88B3);                     // add x17,x1,x2 with 16 regs
    total++; if ({trap_valid, trap_cause, addrin, retired} !== {1'b1, 4'd2, 32'h100, 32'd9}) begin bad++; $display("FAIL rv32e_trap got=%b/%0d/%h/%0d want=1/2/100/9", trap_valid, trap_cause, addrin, retired); end
    handshake(32'h0000_0073);                     // ecall
    total++; if ({trap_valid, trap_cause} !== {1'b1, 4'd11}) begin bad++; $display("FAIL ecall got=%b/%0d want=1/11", trap_valid, trap_cause); end
    handshake(32'h0010_0073);                     // ebreak
    total++; if ({trap_valid, trap_cause, retired} !== {1'b1, 4'd3, 32'd9}) begin bad++; $display("FAIL ebreak got=%b/%0d/%0d want=1/3/9", trap_valid, trap_cause, retired); end
  endtask

  task automatic test_misalign;
    handshake(32'h0021_2383);                     // lw x7,2(x2) -> 0x102 @0x100
`ifdef ISS_MISALIGN_TRAP_EN
    total++; if ({trap_valid, trap_cause, addrin, retired} !== {1'b1, 4'd4, 32'h100, 32'd9}) begin bad++; $display("FAIL mis_trap got=%b/%0d/%h/%0d want=1/4/100/9", trap_valid, trap_cause, addrin, retired); end
`else
    total++; if ({trap_valid, addrin, req, mask} !== {1'b0, 32'h102, 1'b0, 3'd2}) begin bad++; $display("FAIL mis_req got=%b/%h/%b/%0d want=0/102/0/2", trap_valid, addrin, req, mask); end
    handshake(32'h55);
    total++; if ({dstdata, retired, addrin} !== {32'h55, 32'd10, 32'h104}) begin bad++; $display("FAIL mis_done got=%h/%0d/%h want=55/10/104", dstdata, retired, addrin); end
`endif
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (!tm_notify && n < 50) begin @(negedge clk); n++; end
    tm_sync = 1'b1; @(negedge clk); tm_sync = 1'b0;
    ld_data = 32'h0070_0293; ld_sync = 1'b1; rst = 1'b0;
    @(negedge clk);
    ld_sync = 1'b0; ld_data = '0;
    total++; if ({rg_notify, fm_notify, tm_notify, addrin, retired} !== {3'b001, 32'h40, 32'd0}) begin bad++; $display("FAIL mid_reset got=%b%b%b/%h/%0d want=001/40/0", rg_notify, fm_notify, tm_notify, addrin, retired); end
    rst = 1'b1; @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_x0_writes();
    test_load();
    test_flow();
    test_trap();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
